// File: rtl/quad_adder_arbiter.sv
// Two-requester front end for a single shared DW-bit adder: arbitrates, latches the
// winner's operands, drives the adder for one cycle and returns the result on the winner's channel.
module quad_adder_arbiter #(
    parameter int DW   = 4,
    parameter bit FAIR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          Req0_Valid,
    output logic          Req0_Ready,
    input  logic [DW-1:0] Req0_A,
    input  logic [DW-1:0] Req0_B,
    output logic          Resp0_Valid,
    input  logic          Resp0_Ready,
    output logic [DW-1:0] Resp0_Sum,
    output logic          Resp0_Overflow,
    input  logic          Req1_Valid,
    output logic          Req1_Ready,
    input  logic [DW-1:0] Req1_A,
    input  logic [DW-1:0] Req1_B,
    output logic          Resp1_Valid,
    input  logic          Resp1_Ready,
    output logic [DW-1:0] Resp1_Sum,
    output logic          Resp1_Overflow,
    output logic [DW-1:0] Add_A,
    output logic [DW-1:0] Add_B,
    input  logic [DW-1:0] Add_Sum,
    input  logic          Add_Overflow,
    output logic          Busy,
    output logic          Grant_Id,
    output logic [1:0]    dbg_state
);

    // Handshake: a transfer happens on a rising edge where Valid and Ready are both high;
    // a requester keeps Valid (and its payload) steady until that edge, and Ready never
    // depends on anything but Valid and internal state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic          last_grant;
    logic          grant_q;
    logic [DW-1:0] a_q, b_q, sum_q;
    logic          ovf_q;
    logic          win;
    logic          accept;
    logic          resp_done;

    // Tie winner: round-robin flips away from the last served requester, else requester 0.
    always_comb begin
        win = 1'b0;
        if (Req0_Valid && Req1_Valid) begin
            win = FAIR ? ~last_grant : 1'b0;
        end else if (Req1_Valid) begin
            win = 1'b1;
        end
    end

    assign accept    = (state == IDLE) && (Req0_Valid || Req1_Valid);
    assign resp_done = (state == RESP) && (grant_q ? Resp1_Ready : Resp0_Ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                grant_q <= win;
                a_q     <= win ? Req1_A : Req0_A;
                b_q     <= win ? Req1_B : Req0_B;
            end
            if (state == ADD) begin
                sum_q <= Add_Sum;
                ovf_q <= Add_Overflow;
            end
            if (resp_done) begin
                last_grant <= grant_q;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ADD;
            ADD:     state_nx = RESP;
            RESP:    if (resp_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        Req0_Ready     = (state == IDLE) && Req0_Valid && !win;
        Req1_Ready     = (state == IDLE) && Req1_Valid && win;
        Add_A          = (state == ADD) ? a_q : '0;
        Add_B          = (state == ADD) ? b_q : '0;
        Resp0_Valid    = (state == RESP) && !grant_q;
        Resp1_Valid    = (state == RESP) && grant_q;
        Resp0_Sum      = Resp0_Valid ? sum_q : '0;
        Resp0_Overflow = Resp0_Valid && ovf_q;
        Resp1_Sum      = Resp1_Valid ? sum_q : '0;
        Resp1_Overflow = Resp1_Valid && ovf_q;
        Busy           = (state != IDLE);
        Grant_Id       = grant_q;
        dbg_state      = state;
    end

endmodule
